// File: rtl/branch_resolver.sv
// Branch/jump resolver sitting after EX: decides taken/not-taken, issues a
// held redirect to fetch, then flushes IF/ID for two cycles.
// Optional statistics counters are enabled with `define BRANCH_STATS_EN;
// without it the count ports are tied to zero.
module branch_resolver (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_valid,
    output logic        o_ready,
    input  logic        i_is_jump,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_target,
    output logic        o_br_un,
    input  logic        i_br_less,
    input  logic        i_br_equal,
    output logic        o_redirect_valid,
    output logic [31:0] o_redirect_pc,
    input  logic        i_redirect_ready,
    output logic        o_flush,
    output logic [31:0] o_branch_count,
    output logic [31:0] o_taken_count
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REDIRECT = 2'd1,
        FLUSH    = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  flush_cnt_q, flush_cnt_d;
    logic [31:0] redirect_pc_q;
    logic        accept;
    logic        taken;
    logic [31:0] aligned_target;

    // Comparator unsigned select follows funct3 directly (BLTU/BGEU)
    always_comb begin
        o_br_un = (i_funct3 == 3'b110) || (i_funct3 == 3'b111);
    end

    // Taken decode from the live EX inputs; only consumed on the accept edge
    always_comb begin
        taken = 1'b0;
        if (i_is_jump) begin
            taken = 1'b1;
        end else begin
            unique case (i_funct3)
                3'b000:         taken = i_br_equal;
                3'b001:         taken = !i_br_equal;
                3'b100, 3'b110: taken = i_br_less;
                3'b101, 3'b111: taken = !i_br_less;
                default:        taken = 1'b0;
            endcase
        end
    end

    assign accept         = i_valid && (state_q == IDLE);
    assign aligned_target = i_target & ~32'd1;

    // Next-state, flush counter and state-decoded outputs
    always_comb begin
        state_d          = state_q;
        flush_cnt_d      = flush_cnt_q;
        o_ready          = 1'b0;
        o_redirect_valid = 1'b0;
        o_flush          = 1'b0;
        unique case (state_q)
            IDLE: begin
                o_ready = 1'b1;
                if (accept && taken) begin
                    state_d = REDIRECT;
                end
            end
            REDIRECT: begin
                o_redirect_valid = 1'b1;
                if (i_redirect_ready) begin
                    state_d     = FLUSH;
                    flush_cnt_d = 2'd1;
                end
            end
            FLUSH: begin
                o_flush = 1'b1;
                if (flush_cnt_q == 2'd0) begin
                    state_d = IDLE;
                end else begin
                    flush_cnt_d = flush_cnt_q - 2'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, flush counter and captured redirect target
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q       <= IDLE;
            flush_cnt_q   <= '0;
            redirect_pc_q <= '0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            if (accept && taken) begin
                redirect_pc_q <= aligned_target;
            end
        end
    end

    assign o_redirect_pc = redirect_pc_q;

`ifdef BRANCH_STATS_EN
    logic [31:0] branch_cnt_q;
    logic [31:0] taken_cnt_q;

    // Saturating statistics counters, updated on each accept
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            branch_cnt_q <= '0;
            taken_cnt_q  <= '0;
        end else if (accept) begin
            if (branch_cnt_q != '1) begin
                branch_cnt_q <= branch_cnt_q + 32'd1;
            end
            if (taken && (taken_cnt_q != '1)) begin
                taken_cnt_q <= taken_cnt_q + 32'd1;
            end
        end
    end

    assign o_branch_count = branch_cnt_q;
    assign o_taken_count  = taken_cnt_q;
`else
    assign o_branch_count = '0;
    assign o_taken_count  = '0;
`endif

endmodule

// File: tb/tb_branch_resolver.sv
// Directed self-checking bench for branch_resolver.
module tb_branch_resolver;

    logic        i_clk = 1'b0;
    logic        i_reset = 1'b0;
    logic        i_valid = 1'b0;
    logic        o_ready;
    logic        i_is_jump = 1'b0;
    logic [2:0]  i_funct3 = 3'b000;
    logic [31:0] i_target = '0;
    logic        o_br_un;
    logic        i_br_less = 1'b0;
    logic        i_br_equal = 1'b0;
    logic        o_redirect_valid;
    logic [31:0] o_redirect_pc;
    logic        i_redirect_ready = 1'b0;
    logic        o_flush;
    logic [31:0] o_branch_count;
    logic [31:0] o_taken_count;

    int total = 0;
    int fails = 0;

    branch_resolver dut (
        .i_clk            (i_clk),
        .i_reset          (i_reset),
        .i_valid          (i_valid),
        .o_ready          (o_ready),
        .i_is_jump        (i_is_jump),
        .i_funct3         (i_funct3),
        .i_target         (i_target),
        .o_br_un          (o_br_un),
        .i_br_less        (i_br_less),
        .i_br_equal       (i_br_equal),
        .o_redirect_valid (o_redirect_valid),
        .o_redirect_pc    (o_redirect_pc),
        .i_redirect_ready (i_redirect_ready),
        .o_flush          (o_flush),
        .o_branch_count   (o_branch_count),
        .o_taken_count    (o_taken_count)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1ns after the edge
    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // Bounded wait for o_ready; an expired budget is a failed check
    task automatic wait_ready(input string tag);
        int n = 0;
        while (o_ready !== 1'b1 && n < 10) begin
            tick();
            n++;
        end
        check(tag, {31'd0, o_ready}, 32'd1);
    endtask

    // One conditional branch from the table: check redirect after 1 cycle
    task automatic cond_case(input string tag, input logic [2:0] f3, input logic eq,
                             input logic lt, input logic exp_taken);
        i_valid = 1'b1; i_is_jump = 1'b0; i_funct3 = f3;
        i_br_equal = eq; i_br_less = lt; i_target = 32'h0000_0040;
        i_redirect_ready = 1'b1;
        tick();
        i_valid = 1'b0;
        check(tag, {31'd0, o_redirect_valid}, {31'd0, exp_taken});
        wait_ready({tag, "_ready"});
    endtask

    initial begin
        // Reset state
        #2;
        check("rst_ready", {31'd0, o_ready}, 32'd1);
        check("rst_rv", {31'd0, o_redirect_valid}, 32'd0);
        check("rst_flush", {31'd0, o_flush}, 32'd0);
        check("rst_pc", o_redirect_pc, 32'd0);
        check("rst_bcnt", o_branch_count, 32'd0);
        check("rst_tcnt", o_taken_count, 32'd0);
        #10;
        i_reset = 1'b1;
        tick();
        check("post_rst_ready", {31'd0, o_ready}, 32'd1);

        // BEQ taken, fetch ready immediately
        i_valid = 1'b1; i_is_jump = 1'b0; i_funct3 = 3'b000;
        i_br_equal = 1'b1; i_br_less = 1'b0; i_target = 32'h0000_0104;
        i_redirect_ready = 1'b1;
        #1;
        check("beq_brun", {31'd0, o_br_un}, 32'd0);
        tick();
        i_valid = 1'b0;
        check("beq_rv", {31'd0, o_redirect_valid}, 32'd1);
        check("beq_pc", o_redirect_pc, 32'h0000_0104);
        check("beq_ready_busy", {31'd0, o_ready}, 32'd0);
        check("beq_noflush_redir", {31'd0, o_flush}, 32'd0);
        tick();
        check("beq_flush1", {31'd0, o_flush}, 32'd1);
        check("beq_rv_fl1", {31'd0, o_redirect_valid}, 32'd0);
        tick();
        check("beq_flush2", {31'd0, o_flush}, 32'd1);
        check("beq_ready_fl2", {31'd0, o_ready}, 32'd0);
        tick();
        check("beq_flush_end", {31'd0, o_flush}, 32'd0);
        check("beq_ready_back", {31'd0, o_ready}, 32'd1);
`ifdef BRANCH_STATS_EN
        check("beq_bcnt", o_branch_count, 32'd1);
        check("beq_tcnt", o_taken_count, 32'd1);
`else
        check("beq_bcnt_off", o_branch_count, 32'd0);
        check("beq_tcnt_off", o_taken_count, 32'd0);
`endif

        // BGEU not taken
        i_valid = 1'b1; i_funct3 = 3'b111; i_br_less = 1'b1; i_br_equal = 1'b0;
        #1;
        check("bgeu_brun", {31'd0, o_br_un}, 32'd1);
        tick();
        i_valid = 1'b0;
        check("bgeu_rv", {31'd0, o_redirect_valid}, 32'd0);
        check("bgeu_flush", {31'd0, o_flush}, 32'd0);
        check("bgeu_ready", {31'd0, o_ready}, 32'd1);
        check("bgeu_pc_kept", o_redirect_pc, 32'h0000_0104);

        // JALR with fetch stalled 3 cycles; i_valid held and inputs perturbed
        i_valid = 1'b1; i_is_jump = 1'b1; i_funct3 = 3'b000;
        i_target = 32'h0000_2003; i_redirect_ready = 1'b0;
        tick();
        i_target = 32'hDEAD_BEEF; i_funct3 = 3'b110;
        for (int c = 0; c < 3; c++) begin
            check("jalr_rv_stall", {31'd0, o_redirect_valid}, 32'd1);
            check("jalr_pc_stall", o_redirect_pc, 32'h0000_2002);
            check("jalr_ready_stall", {31'd0, o_ready}, 32'd0);
            tick();
        end
        i_redirect_ready = 1'b1;
        check("jalr_rv_last", {31'd0, o_redirect_valid}, 32'd1);
        check("jalr_pc_last", o_redirect_pc, 32'h0000_2002);
        tick();
        i_valid = 1'b0;
        check("jalr_flush1", {31'd0, o_flush}, 32'd1);
        tick();
        check("jalr_flush2", {31'd0, o_flush}, 32'd1);
        tick();
        check("jalr_idle", {31'd0, o_ready}, 32'd1);
        check("jalr_pc_after", o_redirect_pc, 32'h0000_2002);

        // Decode table for the remaining conditions
        i_is_jump = 1'b0;
        cond_case("bne_t",   3'b001, 1'b0, 1'b0, 1'b1);
        cond_case("bne_nt",  3'b001, 1'b1, 1'b0, 1'b0);
        cond_case("beq_nt",  3'b000, 1'b0, 1'b0, 1'b0);
        cond_case("blt_t",   3'b100, 1'b0, 1'b1, 1'b1);
        cond_case("bge_nt",  3'b101, 1'b0, 1'b1, 1'b0);
        cond_case("bge_t",   3'b101, 1'b0, 1'b0, 1'b1);
        cond_case("bltu_nt", 3'b110, 1'b0, 1'b0, 1'b0);
        cond_case("f011_nt", 3'b011, 1'b1, 1'b1, 1'b0);

        // Reset during first FLUSH cycle
        i_valid = 1'b1; i_funct3 = 3'b000; i_br_equal = 1'b1;
        i_target = 32'h0000_0300; i_redirect_ready = 1'b1;
        tick();
        i_valid = 1'b0;
        tick();
        check("rstfl_flush_before", {31'd0, o_flush}, 32'd1);
        #2;
        i_reset = 1'b0;
        #1;
        check("rstfl_flush_drop", {31'd0, o_flush}, 32'd0);
        check("rstfl_rv_drop", {31'd0, o_redirect_valid}, 32'd0);
        check("rstfl_pc_clr", o_redirect_pc, 32'd0);
        check("rstfl_bcnt_clr", o_branch_count, 32'd0);
        @(negedge i_clk);
        i_reset = 1'b1;
        tick();
        check("rstfl_ready", {31'd0, o_ready}, 32'd1);
        tick();
        check("rstfl_no_replay", {31'd0, o_redirect_valid}, 32'd0);
        check("rstfl_no_flush", {31'd0, o_flush}, 32'd0);

        // funct3=010 with eq=1: not taken
        i_valid = 1'b1; i_funct3 = 3'b010; i_br_equal = 1'b1; i_br_less = 1'b0;
        tick();
        i_valid = 1'b0;
        check("f010_rv", {31'd0, o_redirect_valid}, 32'd0);
        check("f010_ready", {31'd0, o_ready}, 32'd1);
`ifdef BRANCH_STATS_EN
        check("f010_bcnt", o_branch_count, 32'd1);
        check("f010_tcnt", o_taken_count, 32'd0);

        // Saturation with preloaded counters
        force dut.branch_cnt_q = 32'hFFFF_FFFF;
        force dut.taken_cnt_q  = 32'hFFFF_FFFF;
        #1;
        release dut.branch_cnt_q;
        release dut.taken_cnt_q;
        i_valid = 1'b1; i_is_jump = 1'b1; i_target = 32'h0000_0500;
        tick();
        i_valid = 1'b0; i_is_jump = 1'b0;
        check("sat_bcnt", o_branch_count, 32'hFFFF_FFFF);
        check("sat_tcnt", o_taken_count, 32'hFFFF_FFFF);
        wait_ready("sat_ready");
`else
        check("f010_bcnt_off", o_branch_count, 32'd0);
        check("f010_tcnt_off", o_taken_count, 32'd0);
`endif

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule

// File: doc/branch_resolver.md
BRANCH_RESOLVER -- requirements
Module: branch_resolver

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with these ports: i_clk in 1, clock, all state on rising edge; i_reset in 1, asynchronous active-low reset.
REQ-002 i_valid in 1: branch/jump instruction offered from EX.
REQ-003 o_ready out 1: resolver can accept; transfer occurs when i_valid & o_ready at rising edge.
REQ-004 i_is_jump in 1: unconditional (JAL/JALR); when 0, instruction is a conditional branch.
REQ-005 i_funct3 in 3: branch condition code.
REQ-006 i_target in 32: computed branch/jump target.
REQ-007 o_br_un out 1: unsigned-compare select driven back to the branch comparator.
REQ-008 i_br_less in 1, i_br_equal in 1: comparator flags; i_br_equal = 1 when operands are equal.
REQ-009 o_redirect_valid out 1, o_redirect_pc out 32: redirect request to fetch.
REQ-010 i_redirect_ready in 1: fetch accepts redirect.
REQ-011 o_flush out 1: kill younger instructions in IF/ID.
REQ-012 o_branch_count out 32, o_taken_count out 32: statistics (see Configuration).

Function
REQ-013 o_br_un SHALL be combinational: 1 when i_funct3 is 110 or 111, else 0, independent of state.
REQ-014 Taken SHALL be decoded as follows: i_is_jump -> 1; 000 -> eq; 001 -> !eq; 100/110 -> less; 101/111 -> !less; 010/011 -> 0 (not taken, no redirect).
REQ-015 States SHALL be IDLE, REDIRECT, FLUSH; o_ready = 1 only in IDLE.
REQ-016 IDLE, accepted and taken: SHALL register {i_target[31:1],1'b0} into o_redirect_pc and go to REDIRECT next cycle.
REQ-017 IDLE, accepted and not taken: SHALL remain in IDLE; no redirect and no flush are issued.
REQ-018 REDIRECT: o_redirect_valid SHALL be 1 and o_redirect_pc SHALL be held stable until i_redirect_ready = 1; on the accepting edge the block SHALL go to FLUSH.
REQ-019 FLUSH: o_flush SHALL be 1 for exactly 2 cycles (2-bit down-counter loaded with 1), o_redirect_valid SHALL be 0, then the block SHALL return to IDLE.
REQ-020 o_flush SHALL be 0 in IDLE and REDIRECT.
REQ-021 Minimum latency from accept to o_redirect_valid SHALL be 1 cycle; minimum taken-branch occupancy SHALL be 4 cycles (accept, REDIRECT, FLUSH x2).
REQ-022 i_valid in non-IDLE states SHALL be ignored; upstream must hold it while o_ready = 0.
REQ-023 If i_redirect_ready is already high in the first REDIRECT cycle, the redirect SHALL complete in that one cycle.
REQ-024 Flags, funct3 and target SHALL be sampled only on the accept edge; later changes SHALL have no effect.

Reset
REQ-025 Asserting i_reset low SHALL force IDLE immediately, asynchronously, including mid-REDIRECT or mid-FLUSH.
REQ-026 On reset, o_redirect_valid = 0, o_flush = 0, o_redirect_pc = 0, flush counter = 0, and both statistics counters = 0.
REQ-027 o_ready SHALL be 1 from the first edge after reset release.
REQ-028 No redirect pending at reset SHALL be replayed after release.

Configuration
REQ-029 With BRANCH_STATS_EN defined, o_branch_count SHALL increment on every accepted instruction and o_taken_count on every accepted taken one.
REQ-030 With BRANCH_STATS_EN defined, both counters SHALL saturate at 32'hFFFF_FFFF.
REQ-031 Without BRANCH_STATS_EN, the ports SHALL exist, be tied to 0, and no counter flops SHALL be synthesized.
REQ-032 All other behaviour SHALL be identical with and without BRANCH_STATS_EN.

Verification
REQ-033 BEQ taken: funct3=000, eq=1, target=0x0000_0104, redirect_ready=1 -> o_redirect_valid for 1 cycle with pc 0x104, then o_flush=1 for 2 cycles, o_ready back after 4 cycles.
REQ-034 BGEU not taken: funct3=111, less=1 -> o_br_un=1, no redirect, no flush, o_ready stays 1.
REQ-035 JALR, target=0x0000_2003, redirect_ready held 0 for 3 cycles -> o_redirect_pc=0x2002 stable 4 cycles, i_valid ignored throughout.
REQ-036 Reset asserted during first FLUSH cycle -> o_flush and o_redirect_valid drop immediately, IDLE and o_ready=1 after release.
REQ-037 funct3=010 with eq=1 -> not taken; with BRANCH_STATS_EN, branch_count +1, taken_count unchanged.
REQ-038 BRANCH_STATS_EN defined, counters preloaded to 0xFFFF_FFFF via force, one taken branch -> both counters stay 0xFFFF_FFFF.
